// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: protocol constants and FSM state encoding shared by the
// UART command parser and its testbench.
package uart_cmd_pkg;

    localparam logic [7:0] OPC_WR  = 8'h57;  // 'W'
    localparam logic [7:0] OPC_RD  = 8'h52;  // 'R'
    localparam logic [7:0] RSP_ACK = 8'h4B;  // 'K'
    localparam logic [7:0] RSP_ERR = 8'h45;  // 'E'

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        CSUM,
        REQ,
        WAIT_RSP,
        TX_RSP,
        TX_ERR
    } state_t;

    // True for the two opcodes the parser understands.
    function automatic logic is_opcode(input logic [7:0] b);
        return (b == OPC_WR) || (b == OPC_RD);
    endfunction

endpackage

// File: rtl/uart_cmd_ser.sv
// uart_cmd_ser: generic N-byte, MSB-first parallel-to-AXI-Stream serializer.
// A load captures a left-aligned word and a byte count; bytes are then
// presented one at a time, each held until the sink accepts it.
module uart_cmd_ser #(
    parameter int NBYTES = 4,
    parameter int LEN_W  = $clog2(NBYTES + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [8*NBYTES-1:0] load_data,
    input  logic [LEN_W-1:0]    load_len,
    output logic [7:0]          m_axis_tdata,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic                done
);

    logic [8*NBYTES-1:0] shreg;
    logic [LEN_W-1:0]    remaining;
    logic                hs;

    assign m_axis_tvalid = (remaining != '0);
    assign m_axis_tdata  = shreg[8*NBYTES-1 -: 8];
    assign hs            = m_axis_tvalid && m_axis_tready;
    assign done          = hs && (remaining == LEN_W'(1));

    // Capture a new word on load, otherwise move the next byte to the top after each accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: clocked state always uses non-blocking (<=) so every register samples pre-edge values.
        if (rst) begin
            shreg     <= '0;
            remaining <= '0;
        end else if (load) begin
            shreg     <= load_data;
            remaining <= load_len;
        end else if (hs) begin
            shreg     <= shreg << 8;
            remaining <= remaining - 1'b1;
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: binary read/write command decoder between the UART RX and
// TX AXI-Streams. Assembles opcode/address/data frames, issues one register
// request, and returns 'K', the read data, or 'E'.
// Optional build macro UART_CMD_CSUM_EN: frames carry a trailing XOR checksum.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [7:0]        m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_we,
    output logic [ADDR_W-1:0] req_addr,
    output logic [DATA_W-1:0] req_wdata,
    input  logic              rsp_valid,
    input  logic [DATA_W-1:0] rsp_rdata,
    output logic              err_timeout,
    output logic              err_opcode
);

    localparam int ADDR_NB = ADDR_W / 8;
    localparam int DATA_NB = DATA_W / 8;
    localparam int MAX_NB  = (ADDR_NB > DATA_NB) ? ADDR_NB : DATA_NB;
    localparam int BCNT_W  = (MAX_NB > 1) ? $clog2(MAX_NB) : 1;
    localparam int TO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int LEN_W   = $clog2(DATA_NB + 1);

    localparam logic [BCNT_W-1:0] ADDR_LAST = BCNT_W'(ADDR_NB - 1);
    localparam logic [BCNT_W-1:0] DATA_LAST = BCNT_W'(DATA_NB - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

    // Single-byte responses are left-aligned so the serializer sends them first.
    localparam logic [DATA_W-1:0] ACK_WORD = DATA_W'(RSP_ACK) << (DATA_W - 8);
    localparam logic [DATA_W-1:0] ERR_WORD = DATA_W'(RSP_ERR) << (DATA_W - 8);

    // State that follows the last address/data byte of a frame.
`ifdef UART_CMD_CSUM_EN
    localparam state_t FRAME_END = CSUM;
`else
    localparam state_t FRAME_END = REQ;
`endif

    state_t            state;
    state_t            state_nxt;
    logic              rx_fire;
    logic              in_frame;
    logic              timeout_hit;
    logic [BCNT_W-1:0] byte_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic              err_opc_set;
    logic              ser_load;
    logic [DATA_W-1:0] ser_data;
    logic [LEN_W-1:0]  ser_len;
    logic              ser_done;
`ifdef UART_CMD_CSUM_EN
    logic [7:0]        csum;
`endif

    assign rx_fire     = s_axis_tvalid && s_axis_tready;
    assign in_frame    = (state == ADDR) || (state == DATA) || (state == CSUM);
    assign timeout_hit = in_frame && !rx_fire && (to_cnt == TO_LAST);
    assign req_valid   = (state == REQ);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode plus serializer load and opcode-error strobe.
    always_comb begin
        // NOTE: every output of this block gets a default first; a path that skips one would infer a latch.
        state_nxt   = state;
        err_opc_set = 1'b0;
        ser_load    = 1'b0;
        ser_data    = '0;
        ser_len     = '0;
        case (state)
            IDLE: begin
                if (rx_fire) begin
                    if (is_opcode(s_axis_tdata)) begin
                        state_nxt = ADDR;
                    end else begin
                        state_nxt   = TX_ERR;
                        err_opc_set = 1'b1;
                        ser_load    = 1'b1;
                        ser_data    = ERR_WORD;
                        ser_len     = LEN_W'(1);
                    end
                end
            end
            ADDR: begin
                if (rx_fire) begin
                    if (byte_cnt == ADDR_LAST) state_nxt = req_we ? DATA : FRAME_END;
                end else if (timeout_hit) begin
                    state_nxt = IDLE;
                end
            end
            DATA: begin
                if (rx_fire) begin
                    if (byte_cnt == DATA_LAST) state_nxt = FRAME_END;
                end else if (timeout_hit) begin
                    state_nxt = IDLE;
                end
            end
`ifdef UART_CMD_CSUM_EN
            CSUM: begin
                if (rx_fire) begin
                    if (s_axis_tdata == csum) begin
                        state_nxt = REQ;
                    end else begin
                        state_nxt   = TX_ERR;
                        err_opc_set = 1'b1;
                        ser_load    = 1'b1;
                        ser_data    = ERR_WORD;
                        ser_len     = LEN_W'(1);
                    end
                end else if (timeout_hit) begin
                    state_nxt = IDLE;
                end
            end
`endif
            REQ: begin
                // A response strobe here is ignored; only the handshake moves on.
                if (req_ready) state_nxt = WAIT_RSP;
            end
            WAIT_RSP: begin
                if (rsp_valid) begin
                    state_nxt = TX_RSP;
                    ser_load  = 1'b1;
                    ser_data  = req_we ? ACK_WORD : rsp_rdata;
                    ser_len   = req_we ? LEN_W'(1) : LEN_W'(DATA_NB);
                end
            end
            TX_RSP, TX_ERR: begin
                if (ser_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Frame assembly: opcode latch, MSB-first address/data shifting, byte counter, running checksum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            byte_cnt  <= '0;
`ifdef UART_CMD_CSUM_EN
            csum      <= '0;
`endif
        end else if (rx_fire) begin
            case (state)
                IDLE: begin
                    if (is_opcode(s_axis_tdata)) begin
                        req_we    <= (s_axis_tdata == OPC_WR);
                        req_addr  <= '0;
                        req_wdata <= '0;
                        byte_cnt  <= '0;
                    end
`ifdef UART_CMD_CSUM_EN
                    csum <= s_axis_tdata;
`endif
                end
                ADDR: begin
                    req_addr <= (req_addr << 8) | ADDR_W'(s_axis_tdata);
                    byte_cnt <= (byte_cnt == ADDR_LAST) ? '0 : byte_cnt + 1'b1;
`ifdef UART_CMD_CSUM_EN
                    csum <= csum ^ s_axis_tdata;
`endif
                end
                DATA: begin
                    req_wdata <= (req_wdata << 8) | DATA_W'(s_axis_tdata);
                    byte_cnt  <= (byte_cnt == DATA_LAST) ? '0 : byte_cnt + 1'b1;
`ifdef UART_CMD_CSUM_EN
                    csum <= csum ^ s_axis_tdata;
`endif
                end
                default: ;
            endcase
        end
    end

    // Inter-byte timeout: counts idle cycles inside a frame, held at zero elsewhere.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                   to_cnt <= '0;
        else if (!in_frame || rx_fire || timeout_hit) to_cnt <= '0;
        else                                       to_cnt <= to_cnt + 1'b1;
    end

    // Registered RX ready and error pulses, so all of them read 0 while reset is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_axis_tready <= 1'b0;
            err_opcode    <= 1'b0;
            err_timeout   <= 1'b0;
        end else begin
            s_axis_tready <= (state_nxt == IDLE) || (state_nxt == ADDR) ||
                             (state_nxt == DATA) || (state_nxt == CSUM);
            err_opcode    <= err_opc_set;
            err_timeout   <= timeout_hit;
        end
    end

    uart_cmd_ser #(
        .NBYTES (DATA_NB),
        .LEN_W  (LEN_W)
    ) u_ser (
        .clk           (clk),
        .rst           (rst),
        .load          (ser_load),
        .load_data     (ser_data),
        .load_len      (ser_len),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .done          (ser_done)
    );

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: scoreboard bench for uart_cmd_parser. Directed frames
// push expected requests and TX bytes into queues; a monitor pops and
// compares whenever the DUT completes a handshake. Honours UART_CMD_CSUM_EN.
module tb_uart_cmd_parser;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        err_timeout;
    logic        err_opcode;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  exp_tx[$];
    req_t        exp_req[$];
    int          req_stall   = 2;
    int          rsp_delay   = 2;
    logic [31:0] rd_data     = '0;
    int          tr_mode     = 0;   // 0 always ready, 1 toggle, 2 manual
    int          stall_cnt   = 0;
    int          n_err_opc   = 0;
    int          n_err_to    = 0;

    uart_cmd_parser #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (100)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .err_timeout   (err_timeout),
        .err_opcode    (err_opcode)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // TX sink ready pattern.
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (tr_mode == 1)      m_axis_tready = ~m_axis_tready;
            else if (tr_mode == 0) m_axis_tready = 1'b1;
        end
    end

    // Fabric model: stall the request req_stall cycles, then answer after rsp_delay cycles.
    initial begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        forever begin
            @(negedge clk);
            if (req_valid && !rst) begin
                repeat (req_stall) @(posedge clk);
                #1 req_ready = 1'b1;
                @(posedge clk);
                #1 req_ready = 1'b0;
                repeat (rsp_delay) @(posedge clk);
                #1 rsp_valid = 1'b1;
                rsp_rdata = rd_data;
                @(posedge clk);
                #1 rsp_valid = 1'b0;
                rsp_rdata = '0;
            end
        end
    end

    // Monitor: scoreboard pops on handshakes plus hold-stability checks while stalled.
    initial begin
        logic       tx_stalled;
        logic [7:0] tx_hold;
        logic       rq_stalled;
        req_t       rq_hold;
        req_t       e;
        logic [7:0] eb;
        tx_stalled = 1'b0;
        rq_stalled = 1'b0;
        tx_hold    = '0;
        rq_hold    = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                tx_stalled = 1'b0;
                rq_stalled = 1'b0;
            end else begin
                if (tx_stalled && m_axis_tvalid) check("tx_hold", m_axis_tdata, tx_hold);
                if (m_axis_tvalid && m_axis_tready) begin
                    if (exp_tx.size() == 0) fail("tx_unexpected");
                    else begin
                        eb = exp_tx.pop_front();
                        check("tx_byte", m_axis_tdata, eb);
                    end
                end
                tx_stalled = m_axis_tvalid && !m_axis_tready;
                tx_hold    = m_axis_tdata;

                if (req_valid) check("rx_blocked_in_req", s_axis_tready, 1'b0);
                if (rq_stalled && req_valid) check("req_hold", {req_we, req_addr, req_wdata}, rq_hold);
                if (req_valid && !req_ready) stall_cnt++;
                if (req_valid && req_ready) begin
                    if (exp_req.size() == 0) fail("req_unexpected");
                    else begin
                        e = exp_req.pop_front();
                        check("req_we", req_we, e.we);
                        check("req_addr", req_addr, e.addr);
                        if (e.we) check("req_wdata", req_wdata, e.wdata);
                    end
                end
                rq_stalled = req_valid && !req_ready;
                rq_hold    = {req_we, req_addr, req_wdata};

                if (err_opcode)  n_err_opc++;
                if (err_timeout) n_err_to++;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        s_axis_tdata  = b;
        s_axis_tvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (s_axis_tready) break;
            n++;
            if (n > 500) begin
                fail("rx_accept_timeout");
                break;
            end
        end
        @(posedge clk);
        #1 s_axis_tvalid = 1'b0;
    endtask

    task automatic send_write(input logic [31:0] a, input logic [31:0] d);
        logic [7:0] x;
        x = 8'h57;
        send_byte(8'h57);
        for (int i = 3; i >= 0; i--) begin
            send_byte(a[8*i +: 8]);
            x ^= a[8*i +: 8];
        end
        for (int i = 3; i >= 0; i--) begin
            send_byte(d[8*i +: 8]);
            x ^= d[8*i +: 8];
        end
`ifdef UART_CMD_CSUM_EN
        send_byte(x);
`endif
    endtask

    task automatic send_read(input logic [31:0] a);
        logic [7:0] x;
        x = 8'h52;
        send_byte(8'h52);
        for (int i = 3; i >= 0; i--) begin
            send_byte(a[8*i +: 8]);
            x ^= a[8*i +: 8];
        end
`ifdef UART_CMD_CSUM_EN
        send_byte(x);
`endif
    endtask

    // Wait until the scoreboard empties and the parser is accepting again.
    task automatic drain(input string name);
        int n = 0;
        while (exp_tx.size() != 0 || exp_req.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > 3000) begin
                fail({name, "_drain_timeout"});
                exp_tx.delete();
                exp_req.delete();
                break;
            end
        end
        repeat (4) @(negedge clk);
        check({name, "_idle_ready"}, s_axis_tready, 1'b1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst           = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_outputs", {s_axis_tready, m_axis_tdata, m_axis_tvalid, req_valid, req_we,
                                req_addr, req_wdata, err_timeout, err_opcode}, '0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 1. Write frame -> 'K'; req_valid one cycle after the last RX byte.
        exp_req.push_back('{we: 1'b1, addr: 32'h0000_1000, wdata: 32'hDEAD_BEEF});
        exp_tx.push_back(8'h4B);
        send_write(32'h0000_1000, 32'hDEAD_BEEF);
        @(negedge clk);
        check("req_latency", req_valid, 1'b1);
        drain("write");

        // 2. Read frame with TX backpressure toggling every cycle.
        tr_mode = 1;
        rd_data = 32'h1234_5678;
        exp_req.push_back('{we: 1'b0, addr: 32'h0000_0004, wdata: '0});
        exp_tx.push_back(8'h12);
        exp_tx.push_back(8'h34);
        exp_tx.push_back(8'h56);
        exp_tx.push_back(8'h78);
        send_read(32'h0000_0004);
        drain("read_toggle");
        tr_mode = 0;

        // 3. Bad opcode -> 'E', one err_opcode pulse, no request; then a clean read.
        exp_tx.push_back(8'h45);
        send_byte(8'h41);
        drain("bad_opcode");
        check("err_opcode_pulses", n_err_opc, 1);
        rd_data = 32'hA5C3_0F01;
        exp_req.push_back('{we: 1'b0, addr: 32'h0000_0010, wdata: '0});
        exp_tx.push_back(8'hA5);
        exp_tx.push_back(8'hC3);
        exp_tx.push_back(8'h0F);
        exp_tx.push_back(8'h01);
        send_read(32'h0000_0010);
        drain("read_after_err");

        // 4. Timeout after a partial frame: pulse 100 cycles after the last byte, nothing sent.
        send_byte(8'h57);
        send_byte(8'h00);
        send_byte(8'h00);
        n = 0;
        forever begin
            @(posedge clk);
            n++;
            #1;
            if (err_timeout || n >= 200) break;
        end
        check("timeout_cycles", n, 100);
        repeat (5) @(negedge clk);
        check("err_timeout_pulses", n_err_to, 1);
        check("timeout_idle_ready", s_axis_tready, 1'b1);
        @(posedge clk);
        #1;
        exp_req.push_back('{we: 1'b1, addr: 32'h0000_0020, wdata: 32'h0102_0304});
        exp_tx.push_back(8'h4B);
        send_write(32'h0000_0020, 32'h0102_0304);
        drain("after_timeout");

        // 5. Request backpressure for 50 cycles; fields held, RX blocked, accepted on first ready.
        req_stall = 50;
        stall_cnt = 0;
        exp_req.push_back('{we: 1'b1, addr: 32'hCAFE_0004, wdata: 32'h5555_AAAA});
        exp_tx.push_back(8'h4B);
        send_write(32'hCAFE_0004, 32'h5555_AAAA);
        drain("req_backpressure");
        check("req_stall_cycles", stall_cnt, 50);
        req_stall = 2;

        // 6. Reset while the second read byte is on TX, then a fresh read.
        tr_mode       = 2;
        m_axis_tready = 1'b0;
        rd_data       = 32'hCAFE_F00D;
        exp_req.push_back('{we: 1'b0, addr: 32'h0000_0008, wdata: '0});
        exp_tx.push_back(8'hCA);
        exp_tx.push_back(8'hFE);
        exp_tx.push_back(8'hF0);
        exp_tx.push_back(8'h0D);
        send_read(32'h0000_0008);
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (m_axis_tvalid || n > 500) break;
        end
        @(posedge clk);
        #1 m_axis_tready = 1'b1;
        @(posedge clk);
        #1 m_axis_tready = 1'b0;
        @(negedge clk);
        check("second_byte_presented", {m_axis_tvalid, m_axis_tdata}, {1'b1, 8'hFE});
        #2 rst = 1'b1;
        #1;
        check("reset_mid_tx_outputs", {s_axis_tready, m_axis_tdata, m_axis_tvalid, req_valid, req_we,
                                       req_addr, req_wdata, err_timeout, err_opcode}, '0);
        check("reset_drops_tail", exp_tx.size(), 3);
        exp_tx.delete();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tr_mode       = 0;
        m_axis_tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rd_data = 32'h0BAD_F00D;
        exp_req.push_back('{we: 1'b0, addr: 32'h0000_0008, wdata: '0});
        exp_tx.push_back(8'h0B);
        exp_tx.push_back(8'hAD);
        exp_tx.push_back(8'hF0);
        exp_tx.push_back(8'h0D);
        send_read(32'h0000_0008);
        drain("read_after_reset");

`ifdef UART_CMD_CSUM_EN
        // Checksum mismatch: 52 00 00 00 08 00 -> 'E', no request.
        exp_tx.push_back(8'h45);
        send_byte(8'h52);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h08);
        send_byte(8'h00);
        drain("csum_mismatch");
        check("err_opcode_pulses_final", n_err_opc, 2);
`else
        check("err_opcode_pulses_final", n_err_opc, 1);
`endif
        check("err_timeout_pulses_final", n_err_to, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2_000_000;
        $display("FAIL watchdog_expired");
        n_fail++;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
Command-decode stage directly downstream of the UART core's RX AXI-Stream and upstream of its TX AXI-Stream. It replaces the loopback echo with a binary read/write protocol. It assembles opcode/address/data bytes from the RX stream and issues a single-beat register request to the DDR/control fabric. It then serialises the ack or read data back onto the TX stream.

Parameters:
ADDR_W, 32, request address width; multiple of 8.
DATA_W, 32, request data width; multiple of 8.
TIMEOUT_CYC, 1000000, max idle cycles between RX bytes inside a frame (10 ms at 100 MHz).

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  reset, asynchronous, active-high
s_axis_tdata  in  8  RX byte from UART core
s_axis_tvalid  in  1  RX byte valid
s_axis_tready  out  1  parser accepts RX byte
m_axis_tdata  out  8  TX byte to UART core
m_axis_tvalid  out  1  TX byte valid
m_axis_tready  in  1  UART core accepts TX byte
req_valid  out  1  register request valid
req_ready  in  1  fabric accepts request
req_we  out  1  1 = write, 0 = read
req_addr  out  ADDR_W  request address
req_wdata  out  DATA_W  write data
rsp_valid  in  1  one-cycle response strobe; rdata valid for reads
rsp_rdata  in  DATA_W  read data
err_timeout  out  1  one-cycle pulse on frame timeout
err_opcode  out  1  one-cycle pulse on bad opcode or checksum

Behaviour:
- Frame format: opcode byte, then ADDR_W/8 address bytes MSB first; for writes, then DATA_W/8 data bytes MSB first.
- Opcodes: 0x57 'W' = write, 0x52 'R' = read. Any other value is an error.
- Responses:
  - write: single byte 0x4B 'K'.
  - read: DATA_W/8 bytes of rsp_rdata, MSB first.
  - error: single byte 0x45 'E'.
- Reset values: all outputs 0; state IDLE; byte counter 0; timeout counter 0.
- FSM states: IDLE, ADDR, DATA, CSUM, REQ, WAIT_RSP, TX_RSP, TX_ERR.
- s_axis_tready = 1 only in IDLE, ADDR, DATA, CSUM. A byte transfers when tvalid && tready.
- Transitions:
  - IDLE: 'W'/'R' -> latch we, go ADDR, clear byte counter. Other byte -> TX_ERR and pulse err_opcode.
  - ADDR: shift byte into addr LSB (addr <= {addr, byte}). After the last address byte: write -> DATA; read -> REQ (or CSUM with macro).
  - DATA: shift into wdata the same way. After the last byte -> REQ (or CSUM with macro).
  - REQ: req_valid = 1, with addr/wdata/we held stable until req_ready. On handshake -> WAIT_RSP and drop req_valid the next cycle.
  - WAIT_RSP: on rsp_valid, capture rsp_rdata into the shift register -> TX_RSP. No timeout applies here; the fabric guarantees a response.
  - TX_RSP: present the current byte with m_axis_tvalid = 1. Hold tdata until m_axis_tready, then advance.
    - Write: 1 byte.
    - Read: DATA_W/8 bytes.
    - After the last handshake -> IDLE.
  - TX_ERR: present 0x45 until handshake -> IDLE.
- Timeout:
  - In ADDR, DATA, CSUM the counter increments each cycle without an RX handshake and clears on each handshake.
  - On reaching TIMEOUT_CYC-1 it pulses err_timeout, discards the partial frame, and goes to IDLE. No TX byte is sent.
  - The counter is held at 0 in all other states.
- Simultaneous events: an RX handshake in the same cycle the timeout would fire wins; the byte is accepted and the counter clears.
- req_ready and rsp_valid in the same cycle: rsp_valid is ignored in REQ. The fabric must not respond before acceptance.
- rsp_valid outside WAIT_RSP is ignored.
- Reset mid-frame or mid-TX: immediate abort, all outputs to reset values. The UART core is reset by the same rst, so no partial TX byte survives.
- Latency:
  - Last RX byte -> req_valid: 1 cycle.
  - rsp_valid -> first m_axis_tvalid: 1 cycle.

Optional Feature:
UART_CMD_CSUM_EN:
- Defined: each frame carries a trailing checksum byte, the XOR of all preceding frame bytes including the opcode. The state after the last address/data byte is CSUM.
  - Match -> REQ.
  - Mismatch -> TX_ERR, pulse err_opcode, no request issued.
  - Running XOR register is reset in IDLE.
- Undefined: CSUM state and XOR register are not built; frames end at the last address/data byte.

Decomposition:
- Package uart_cmd_pkg holds:
  - opcode constants OPC_WR = 8'h57, OPC_RD = 8'h52
  - response constants RSP_ACK = 8'h4B, RSP_ERR = 8'h45
  - FSM state encoding
- One sub-module, uart_cmd_ser: a generic N-byte MSB-first parallel-to-AXIS serializer driving m_axis_*. It is used for both TX_RSP and TX_ERR.

Test Plan:
1. Write: RX 57 00 00 10 00 DE AD BE EF -> one req with we=1, addr=0x00001000, wdata=0xDEADBEEF; rsp_valid -> TX 0x4B.
2. Read: RX 52 00 00 00 04; rsp_rdata=0x12345678 -> TX 12 34 56 78 in order. m_axis_tready is toggled every other cycle; tdata stays stable while stalled.
3. Bad opcode: RX 0x41 -> err_opcode pulse, TX 0x45, no req_valid. Then a valid read frame completes normally.
4. Timeout: RX 57 00 00 then silence for TIMEOUT_CYC (set to 100 in bench) -> err_timeout pulse at cycle 100, no TX, no req. The next frame decodes cleanly.
5. Backpressure: req_ready held low 50 cycles -> s_axis_tready = 0 and req fields stable throughout; accepted on the first high cycle.
6. Reset during TX of the second read byte -> all outputs 0 the same cycle; after release, frame 52 00 00 00 08 works (with UART_CMD_CSUM_EN: append 0x5A -> normal; append 0x00 -> 0x45 error).
